// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the LED matrix serial front-end.
// Optional build macro: RX_GLITCH_FILTER_EN (see sync_edge_det).
package led_matrix_pkg;

    localparam int NLEDS_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FULL
    } rx_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Async pin synchroniser with a rising-edge detector.
// RX_GLITCH_FILTER_EN adds a 2-sample agreement filter on the level.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   init_q;
    logic                   armed_q;
    logic                   lvl;

`ifdef RX_GLITCH_FILTER_EN
    logic filt_q;

    // Level follows the synchroniser only after two equal samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b0;
        end else if (sync_q[SYNC_STAGES-1] == sync_q[SYNC_STAGES-2]) begin
            filt_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif

    // Synchroniser chain, edge history, and arming on a seen-low pin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            init_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
            hist_q  <= lvl;
            init_q  <= 1'b1;
            armed_q <= armed_q | (init_q & ~sync_q[0]);
        end
    end

    assign level_o = lvl;
    assign rise_o  = lvl & ~hist_q & armed_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver feeding the LED column scanner's vbuf.
// Optional build macro: RX_GLITCH_FILTER_EN (edge glitch filter).
module serial_frame_rx
    import led_matrix_pkg::*;
#(
    parameter  int NLEDS       = NLEDS_DEFAULT,
    parameter  int SYNC_STAGES = 2,
    localparam int CNTW        = cnt_width(NLEDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_din,
    input  logic             ser_dclk,
    input  logic             ser_strobe,
    output logic [NLEDS-1:0] vbuf,
    output logic             frame_valid,
    output logic             frame_err,
    output logic [CNTW-1:0]  bit_count,
    output logic             rx_busy
);

    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(NLEDS);

    logic din_s, din_rise_unused;
    logic dclk_rise, dclk_lvl_unused;
    logic strb_rise, strb_lvl_unused;

    rx_state_t        state_q, state_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             ovr_q, ovr_d;
    logic [NLEDS-1:0] shreg_q, shreg_d;
    logic [NLEDS-1:0] vbuf_q, vbuf_d;
    logic             fv_q, fv_d;
    logic             fe_q, fe_d;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_din (
        .clk(clk), .reset(reset), .pin_i(ser_din),
        .level_o(din_s), .rise_o(din_rise_unused)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_dclk (
        .clk(clk), .reset(reset), .pin_i(ser_dclk),
        .level_o(dclk_lvl_unused), .rise_o(dclk_rise)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_strb (
        .clk(clk), .reset(reset), .pin_i(ser_strobe),
        .level_o(strb_lvl_unused), .rise_o(strb_rise)
    );

    // Receiver state, counters, shift register and display buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            ovr_q   <= 1'b0;
            shreg_q <= '0;
            vbuf_q  <= '0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            shreg_q <= shreg_d;
            vbuf_q  <= vbuf_d;
            fv_q    <= fv_d;
            fe_q    <= fe_d;
        end
    end

    // Shift/count first, then length check and latch on the post-shift view
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        shreg_d = shreg_q;
        vbuf_d  = vbuf_q;
        fv_d    = 1'b0;
        fe_d    = 1'b0;
        if (dclk_rise) begin
            shreg_d = {shreg_q[NLEDS-2:0], din_s};
            unique case (state_q)
                IDLE: begin
                    count_d = CNTW'(1);
                    state_d = SHIFT;
                end
                SHIFT: begin
                    count_d = count_q + 1'b1;
                    if (count_d == FULL_CNT) begin
                        state_d = FULL;
                    end
                end
                FULL: begin
                    ovr_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        if (strb_rise) begin
            if (count_d == FULL_CNT && !ovr_d) begin
                vbuf_d = shreg_d;
                fv_d   = 1'b1;
            end else begin
                fe_d = 1'b1;
            end
            count_d = '0;
            ovr_d   = 1'b0;
            state_d = IDLE;
        end
    end

    assign vbuf        = vbuf_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign bit_count   = count_q;
    assign rx_busy     = (count_q != '0);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed self-checking bench for serial_frame_rx.
// Honors RX_GLITCH_FILTER_EN for latency and glitch expectations.
module tb_serial_frame_rx;

`ifdef RX_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ser_din;
    logic        ser_dclk;
    logic        ser_strobe;
    logic [63:0] vbuf;
    logic        frame_valid;
    logic        frame_err;
    logic [6:0]  bit_count;
    logic        rx_busy;

    int total = 0;
    int bad   = 0;

    serial_frame_rx dut (
        .clk(clk),
        .reset(reset),
        .ser_din(ser_din),
        .ser_dclk(ser_dclk),
        .ser_strobe(ser_strobe),
        .vbuf(vbuf),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .bit_count(bit_count),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ser_din  = b;
        ser_dclk = 1'b1;
        tick(4);
        ser_dclk = 1'b0;
        tick(4);
    endtask

    task automatic send_bits(input logic [63:0] p, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(p[i]);
    endtask

    task automatic strobe(output int nv, output int ne, output int at);
        nv = 0; ne = 0; at = 0;
        ser_strobe = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (frame_valid) begin nv++; at = i; end
            if (frame_err) begin ne++; at = i; end
        end
        ser_strobe = 1'b0;
        tick(4);
    endtask

    initial begin
        logic [63:0] p1, p2, p3, p4;
        int nv, ne, at, q;
        p1 = 64'hA5A5_0F0F_1234_8001;
        p2 = 64'h0F1E_2D3C_4B5A_6978;
        p3 = 64'hC3C3_5A5A_FFFF_0001;
        p4 = 64'hDEAD_BEEF_0123_4567;

        reset = 1'b1; ser_din = 1'b0; ser_dclk = 1'b0; ser_strobe = 1'b0;
        tick(3);
        reset = 1'b0;
        q = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_valid || frame_err || rx_busy) q++;
        end
        check("rst_vbuf", vbuf, 64'd0);
        check("rst_cnt", 64'(bit_count), 64'd0);
        check("rst_quiet", 64'(q), 64'd0);

        send_bits(p1, 64);
        check("f1_cnt", 64'(bit_count), 64'd64);
        check("f1_busy", 64'(rx_busy), 64'd1);
        strobe(nv, ne, at);
        check("f1_nv", 64'(nv), 64'd1);
        check("f1_ne", 64'(ne), 64'd0);
        check("f1_lat", 64'(at), 64'(LAT));
        check("f1_vbuf", vbuf, p1);
        check("f1_cnt0", 64'(bit_count), 64'd0);

        send_bits(p2, 63);
        check("s63_cnt", 64'(bit_count), 64'd63);
        strobe(nv, ne, at);
        check("s63_ne", 64'(ne), 64'd1);
        check("s63_nv", 64'(nv), 64'd0);
        check("s63_vbuf", vbuf, p1);
        check("s63_cnt0", 64'(bit_count), 64'd0);

        send_bits(64'h2A, 6);
        send_bits(p3, 64);
        check("ovr_cnt", 64'(bit_count), 64'd64);
        strobe(nv, ne, at);
        check("ovr_ne", 64'(ne), 64'd1);
        check("ovr_nv", 64'(nv), 64'd0);
        check("ovr_vbuf", vbuf, p1);
        send_bits(p2, 64);
        strobe(nv, ne, at);
        check("aft_nv", 64'(nv), 64'd1);
        check("aft_vbuf", vbuf, p2);

        send_bits(p3 >> 1, 63);
        ser_din = p3[0];
        ser_dclk = 1'b1;
        strobe(nv, ne, at);
        ser_dclk = 1'b0;
        tick(4);
        check("same_nv", 64'(nv), 64'd1);
        check("same_ne", 64'(ne), 64'd0);
        check("same_vbuf", vbuf, p3);
        check("same_cnt", 64'(bit_count), 64'd0);

        send_bits(p2 >> 34, 30);
        check("mid_cnt", 64'(bit_count), 64'd30);
        reset = 1'b1;
        tick(2);
        check("mid_vbuf", vbuf, 64'd0);
        check("mid_cnt0", 64'(bit_count), 64'd0);
        check("mid_busy", 64'(rx_busy), 64'd0);
        reset = 1'b0;
        tick(5);
        send_bits(p4, 64);
        check("pre_vbuf", vbuf, 64'd0);
        strobe(nv, ne, at);
        check("new_nv", 64'(nv), 64'd1);
        check("new_vbuf", vbuf, p4);

        ser_dclk = 1'b1;
        tick(1);
        ser_dclk = 1'b0;
        tick(8);
`ifdef RX_GLITCH_FILTER_EN
        check("glitch_cnt", 64'(bit_count), 64'd0);
`else
        check("glitch_cnt", 64'(bit_count), 64'd1);
`endif
        strobe(nv, ne, at);
        check("end_vbuf", vbuf, p4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
